// File: rtl/wb_slave_mux.sv
// Wishbone 1-to-NUM_SLAVES address decoder with registered response path, bus-error, timeout and abort handling.
// Optional error log (err_adr_o/err_to_o/err_cnt_o) is built when WB_SLAVE_MUX_ERRLOG_EN is defined.
module wb_slave_mux #(
   parameter int                            NUM_SLAVES  = 3,
   parameter int                            ADDR_W      = 32,
   parameter int                            DATA_W      = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE    = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK    = {3{32'hFF00_0000}},
   parameter int                            TIMEOUT_CYC = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          m_cyc_i,
   input  logic                          m_stb_i,
   input  logic                          m_we_i,
   input  logic [DATA_W/8-1:0]           m_sel_i,
   input  logic [ADDR_W-1:0]             m_adr_i,
   input  logic [DATA_W-1:0]             m_dat_i,
   output logic [DATA_W-1:0]             m_dat_o,
   output logic                          m_ack_o,
   output logic                          m_err_o,
   output logic [NUM_SLAVES-1:0]         s_stb_o,
   output logic [NUM_SLAVES-1:0]         s_cyc_o,
   output logic                          s_we_o,
   output logic [DATA_W/8-1:0]           s_sel_o,
   output logic [ADDR_W-1:0]             s_adr_o,
   output logic [DATA_W-1:0]             s_dat_o,
   input  logic [NUM_SLAVES*DATA_W-1:0]  s_dat_i,
   input  logic [NUM_SLAVES-1:0]         s_ack_i
`ifdef WB_SLAVE_MUX_ERRLOG_EN
   ,
   output logic [ADDR_W-1:0]             err_adr_o,
   output logic                          err_to_o,
   output logic [15:0]                   err_cnt_o
`endif
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                 state;
   logic [IDX_W-1:0]       sel_idx;
   logic [NUM_SLAVES-1:0]  stb_q;
   logic [CNT_W-1:0]       cnt;

   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic                   start;
   logic                   ack_sel;
   logic                   unmapped_evt;
   logic                   timeout_evt;
   logic [DATA_W-1:0]      rdata;

   // NOTE: every signal gets a default before the loop so no latch is inferred.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      // Walk downwards so the lowest matching index is the one left standing.
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((m_adr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // A request is not taken while an error pulse is still visible to the master.
   assign start        = m_cyc_i && m_stb_i && !m_err_o;
   assign ack_sel      = s_ack_i[sel_idx];
   assign rdata        = s_dat_i[sel_idx*DATA_W +: DATA_W];
   assign unmapped_evt = (state == IDLE) && start && !hit;
   assign timeout_evt  = (state == REQ) && m_cyc_i && !ack_sel && (cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Dropping m_cyc_i removes the slave strobe in the same cycle.
   assign s_stb_o = stb_q & {NUM_SLAVES{m_cyc_i}};
   assign s_cyc_o = stb_q & {NUM_SLAVES{m_cyc_i}};

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel_idx <= '0;
         stb_q   <= '0;
         cnt     <= '0;
         m_ack_o <= 1'b0;
         m_err_o <= 1'b0;
         m_dat_o <= '0;
         s_we_o  <= 1'b0;
         s_sel_o <= '0;
         s_adr_o <= '0;
         s_dat_o <= '0;
      end else begin
         m_ack_o <= 1'b0;
         m_err_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && hit) begin
                  sel_idx <= hit_idx;
                  stb_q   <= NUM_SLAVES'(1) << hit_idx;
                  s_we_o  <= m_we_i;
                  s_sel_o <= m_sel_i;
                  s_adr_o <= m_adr_i;
                  s_dat_o <= m_dat_i;
                  cnt     <= '0;
                  state   <= REQ;
               end else if (unmapped_evt) begin
                  m_err_o <= 1'b1;
               end
            end
            REQ: begin
               if (!m_cyc_i) begin
                  stb_q <= '0;
                  state <= IDLE;
               end else if (ack_sel) begin
                  m_dat_o <= rdata;
                  stb_q   <= '0;
                  m_ack_o <= 1'b1;
                  state   <= RESP;
               end else if (timeout_evt) begin
                  stb_q   <= '0;
                  m_err_o <= 1'b1;
                  state   <= IDLE;
               end else if (cnt != CNT_W'(TIMEOUT_CYC)) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               stb_q <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef WB_SLAVE_MUX_ERRLOG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_adr_o <= '0;
         err_to_o  <= 1'b0;
         err_cnt_o <= '0;
      end else if (unmapped_evt || timeout_evt) begin
         err_adr_o <= timeout_evt ? s_adr_o : m_adr_i;
         err_to_o  <= timeout_evt;
         if (err_cnt_o != 16'hFFFF) begin
            err_cnt_o <= err_cnt_o + 16'd1;
         end
      end
   end
`else
   // Error logging disabled: no log registers exist.
`endif

endmodule

// File: tb/tb_wb_slave_mux.sv
// Bench for wb_slave_mux: vector table driven through a master task, responses checked against a scoreboard queue.
// Error-log outputs are checked when WB_SLAVE_MUX_ERRLOG_EN is defined.
module tb_wb_slave_mux;

   localparam logic [7:0] NEVER = 8'hFF;
   localparam int         NV    = 8;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [7:0]  dly;
      logic [2:0]  mask;
      logic        err;
      logic        to;
      int          lat;
      logic [31:0] rdat;
   } vec_t;

   typedef struct {
      logic        err;
      logic        to;
      logic        chk;
      logic [31:0] dat;
      logic [31:0] adr;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        m_cyc_i, m_stb_i, m_we_i;
   logic [3:0]  m_sel_i;
   logic [31:0] m_adr_i, m_dat_i, m_dat_o;
   logic        m_ack_o, m_err_o;
   logic [2:0]  s_stb_o, s_cyc_o;
   logic        s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [95:0] s_dat_i;
   logic [2:0]  s_ack_i;
`ifdef WB_SLAVE_MUX_ERRLOG_EN
   logic [31:0] err_adr_o;
   logic        err_to_o;
   logic [15:0] err_cnt_o;
`endif

   int   n_cmp = 0;
   int   n_fail = 0;
   int   exp_ecnt = 0;
   exp_t sb[$];
   exp_t e;
   vec_t vecs[NV];

   logic [7:0] slv_dly;
   logic [2:0] force_ack;
   logic [7:0] slv_wait[3];

   wb_slave_mux #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
`ifdef WB_SLAVE_MUX_ERRLOG_EN
      , .err_adr_o(err_adr_o), .err_to_o(err_to_o), .err_cnt_o(err_cnt_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Slave models: each acks once its strobe has been seen for slv_dly cycles.
   assign s_dat_i = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1357_9BDF};

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         slv_wait[i] <= s_stb_o[i] ? slv_wait[i] + 8'd1 : 8'd0;
      end
   end

   always_comb begin
      s_ack_i = force_ack;
      for (int i = 0; i < 3; i++) begin
         if (s_stb_o[i] && slv_dly != NEVER && slv_wait[i] >= slv_dly) begin
            s_ack_i[i] = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every ack/err must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (m_ack_o === 1'b1 || m_err_o === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_resp: got ack=%b err=%b expected none at %0t", m_ack_o, m_err_o, $time);
         end else begin
            e = sb.pop_front();
            check("resp_err", {31'd0, m_err_o}, {31'd0, e.err});
            check("resp_ack", {31'd0, m_ack_o}, {31'd0, !e.err});
            if (e.chk && !e.err) check("rdata", m_dat_o, e.dat);
            if (e.err) begin
               exp_ecnt++;
`ifdef WB_SLAVE_MUX_ERRLOG_EN
               check("err_adr", err_adr_o, e.adr);
               check("err_to", {31'd0, err_to_o}, {31'd0, e.to});
               check("err_cnt", {16'd0, err_cnt_o}, exp_ecnt);
`endif
            end
         end
      end
   end

   task automatic drive_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] sel);
      m_cyc_i = 1'b1;
      m_stb_i = 1'b1;
      m_adr_i = adr;
      m_we_i  = we;
      m_dat_i = dat;
      m_sel_i = sel;
   endtask

   task automatic run_vec(input vec_t v);
      int   n;
      int   stb_n;
      bit   done;
      exp_t x;
      @(negedge clk);
      slv_dly = v.dly;
      drive_req(v.adr, v.we, v.dat, v.sel);
      x.err = v.err;
      x.to  = v.to;
      x.chk = !v.we;
      x.dat = v.rdat;
      x.adr = v.adr;
      sb.push_back(x);
      @(posedge clk);
      n = 0;
      stb_n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("stb_mask", {29'd0, s_stb_o}, {29'd0, v.mask});
            check("cyc_mask", {29'd0, s_cyc_o}, {29'd0, v.mask});
            if (v.mask != 3'b000) begin
               check("s_adr", s_adr_o, v.adr);
               check("s_dat", s_dat_o, v.dat);
               check("s_we_sel", {27'd0, s_we_o, s_sel_o}, {27'd0, v.we, v.sel});
            end
         end
         if (s_stb_o != 3'b000) stb_n++;
         if (m_ack_o === 1'b1 || m_err_o === 1'b1) done = 1'b1;
      end
      check("latency", n, v.lat);
      check("stb_cycles", stb_n, v.lat - 1);
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //          adr            we    dat            sel      dly    mask    err   to    lat rdat
      vecs[0] = '{32'h0200_0010, 1'b0, 32'h0,         4'b1111, 8'd1,  3'b010, 1'b0, 1'b0, 3, 32'hDEAD_BEEF};
      vecs[1] = '{32'h0100_0004, 1'b1, 32'h1234_5678, 4'b0011, 8'd0,  3'b001, 1'b0, 1'b0, 2, 32'h0};
      vecs[2] = '{32'h0500_0000, 1'b0, 32'h0,         4'b1111, 8'd0,  3'b000, 1'b1, 1'b0, 1, 32'h0};
      vecs[3] = '{32'h0300_0020, 1'b0, 32'h0,         4'b1111, NEVER, 3'b100, 1'b1, 1'b1, 9, 32'h0};
      vecs[4] = '{32'h0300_00FF, 1'b0, 32'h0,         4'b1111, 8'd0,  3'b100, 1'b0, 1'b0, 2, 32'hCAFE_F00D};
      vecs[5] = '{32'h01FF_FFFC, 1'b0, 32'h0,         4'b1111, 8'd7,  3'b001, 1'b0, 1'b0, 9, 32'h1357_9BDF};
      vecs[6] = '{32'h0200_0000, 1'b1, 32'hA5A5_5A5A, 4'b1100, 8'd2,  3'b010, 1'b0, 1'b0, 4, 32'h0};
      vecs[7] = '{32'h0000_0000, 1'b0, 32'h0,         4'b0001, 8'd0,  3'b000, 1'b1, 1'b0, 1, 32'h0};

      rst = 1'b1;
      m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
      m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
      slv_dly = NEVER;
      force_ack = 3'b000;
      repeat (2) @(negedge clk);
      check("rst_ack_err", {30'd0, m_ack_o, m_err_o}, 32'd0);
      check("rst_m_dat", m_dat_o, 32'd0);
      check("rst_stb_cyc", {26'd0, s_stb_o, s_cyc_o}, 32'd0);
      check("rst_s_bus", s_adr_o | s_dat_o | {27'd0, s_we_o, s_sel_o}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Master abort: wrong-slave ack is ignored, then cyc drops mid-REQ.
      @(negedge clk);
      slv_dly = NEVER;
      drive_req(32'h0100_0000, 1'b0, 32'h0, 4'b1111);
      @(posedge clk);
      @(negedge clk);
      check("abort_stb", {29'd0, s_stb_o}, 32'd1);
      force_ack = 3'b010;
      @(negedge clk);
      check("foreign_ack_stb", {29'd0, s_stb_o}, 32'd1);
      check("foreign_ack_resp", {30'd0, m_ack_o, m_err_o}, 32'd0);
      force_ack = 3'b000;
      m_cyc_i = 1'b0;
      #1;
      check("abort_stb_drop", {26'd0, s_stb_o, s_cyc_o}, 32'd0);
      m_stb_i = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_quiet", {30'd0, m_ack_o, m_err_o}, 32'd0);
      run_vec(vecs[1]);

      // Reset in REQ while the selected slave acks.
      @(negedge clk);
      slv_dly = NEVER;
      drive_req(32'h0100_0008, 1'b0, 32'h0, 4'b1111);
      @(posedge clk);
      @(negedge clk);
      check("prerst_stb", {29'd0, s_stb_o}, 32'd1);
      force_ack = 3'b001;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_resp", {30'd0, m_ack_o, m_err_o}, 32'd0);
      check("midrst_stb", {26'd0, s_stb_o, s_cyc_o}, 32'd0);
      check("midrst_m_dat", m_dat_o, 32'd0);
      check("midrst_s_adr", s_adr_o, 32'd0);
      force_ack = 3'b000;
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
      exp_ecnt = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("postrst_resp", {30'd0, m_ack_o, m_err_o}, 32'd0);
      run_vec(vecs[2]);
      run_vec(vecs[0]);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Parametrised 1-master to NUM_SLAVES-slave Wishbone (classic, single-cycle strobe) address decoder and response multiplexer.
- Sits between the SoC Wishbone master port and the peripheral slaves: PTP timer core, PTP frame generator, TSS controller.
- Replaces shared-wire ack/data hookups with per-slave strobes and a registered response path.
- Adds a bus-error response for unmapped addresses, a response timeout, and master-abort handling.

Parameters:
- NUM_SLAVES, 3, number of slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- SLV_BASE, {32'h0300_0000,32'h0200_0000,32'h0100_0000}, packed NUM_SLAVES*ADDR_W base addresses; slave i at bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, {3{32'hFF00_0000}}, packed NUM_SLAVES*ADDR_W decode masks.
- TIMEOUT_CYC, 255, maximum cycles waiting for a slave ack before an error response (1..65535).

Ports:
- clk  in  1  bus clock.
- rst  in  1  synchronous reset, active high.
- m_cyc_i  in  1  master cycle.
- m_stb_i  in  1  master strobe.
- m_we_i  in  1  write enable.
- m_sel_i  in  DATA_W/8  byte selects.
- m_adr_i  in  ADDR_W  address.
- m_dat_i  in  DATA_W  write data.
- m_dat_o  out  DATA_W  read data.
- m_ack_o  out  1  transfer ack.
- m_err_o  out  1  bus error.
- s_stb_o  out  NUM_SLAVES  per-slave strobe.
- s_cyc_o  out  NUM_SLAVES  per-slave cycle.
- s_we_o  out  1  shared write enable.
- s_sel_o  out  DATA_W/8  shared byte selects.
- s_adr_o  out  ADDR_W  shared address.
- s_dat_o  out  DATA_W  shared write data.
- s_dat_i  in  NUM_SLAVES*DATA_W  packed slave read data.
- s_ack_i  in  NUM_SLAVES  per-slave ack.

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0.
- Decode: slave i matches when (m_adr_i & SLV_MASK[i]) == SLV_BASE[i]. Lowest matching index wins.

State machine (IDLE, REQ, RESP):
- IDLE:
  - On m_cyc_i & m_stb_i & match, register sel_idx and latch adr/dat/we/sel onto the s_*_o buses, then go to REQ.
  - On m_cyc_i & m_stb_i with no match, assert m_err_o for 1 cycle on the next clock and stay IDLE-equivalent; m_ack_o stays 0.
- REQ:
  - s_stb_o[sel_idx] and s_cyc_o[sel_idx] are 1; all other bits 0. The timeout counter increments each cycle.
  - On s_ack_i[sel_idx]: capture s_dat_i slice into m_dat_o, deassert the slave strobe, go to RESP.
  - If the counter reaches TIMEOUT_CYC with no ack: deassert the strobe, assert m_err_o for 1 cycle, go to IDLE.
- RESP: m_ack_o = 1 for exactly 1 cycle, then IDLE.
- Latency: a slave acking in the same cycle it sees its strobe gives m_ack_o 2 cycles after the master strobe is sampled.
- Only one outstanding transfer. The master must drop or hold m_stb_i until ack or err; a held strobe in the cycle after ack/err is sampled as a new transfer.

Boundary conditions:
- Ack from a non-selected slave: ignored.
- Ack and timeout in the same cycle: ack wins.
- Master abort (m_cyc_i low while in REQ): strobe dropped that cycle, return to IDLE, no ack/err.
- m_dat_o holds the last read data until the next captured ack. Write transfers also capture it, with no meaning.
- rst mid-transfer: all outputs 0 on the next cycle; no ack/err is emitted.
- TIMEOUT_CYC counter width: $clog2(TIMEOUT_CYC+1); the counter saturates and never wraps.

Optional Feature:
- Macro WB_SLAVE_MUX_ERRLOG_EN.
- When defined, add outputs:
  - err_adr_o [ADDR_W]: address of the last transfer ending in m_err_o.
  - err_to_o [1]: 1 if that error was a timeout, 0 if unmapped.
  - err_cnt_o [16]: saturating error count.
  - All three reset to 0 and update in the cycle m_err_o is asserted.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Read 0x0200_0010; slave1 acks 1 cycle after its strobe with 0xDEADBEEF -> only s_stb_o = 3'b010; m_ack_o = 1 with m_dat_o = 0xDEADBEEF, 3 cycles after m_stb_i.
- Write 0x0100_0004 data 0x12345678 sel 4'b0011 -> s_stb_o = 3'b001; s_dat_o = 0x12345678, s_sel_o = 4'b0011, s_we_o = 1; single m_ack_o pulse.
- Access 0x0500_0000 (unmapped) -> no s_stb_o bit set; m_err_o pulses 1 cycle; with ERRLOG: err_adr_o = 0x0500_0000, err_to_o = 0, err_cnt_o = 1.
- Slave2 never acks, TIMEOUT_CYC = 8 -> s_stb_o[2] high for 8 cycles then low; m_err_o 1 cycle; m_ack_o stays 0; with ERRLOG: err_to_o = 1.
- Slave0 strobed; slave1 asserts ack, then m_cyc_i dropped mid-REQ -> no m_ack_o/m_err_o; s_stb_o = 0 the same cycle; next access to slave0 proceeds normally.
- rst asserted while in REQ with slave0 acking the same cycle -> all outputs 0 the next cycle, no m_ack_o pulse.
